// File: rtl/vga_box_scheduler.sv
// vga_box_scheduler
// Shares the single VGA adapter write port among NUM_REQ box-draw requesters
// and one full-screen clear requester. Box requesters are served round-robin;
// a pending clear always wins when the scheduler is idle. A granted box is
// drawn as BOX_W x BOX_H back-to-back pixel writes in raster order, and a
// clear scans the whole SCR_W x SCR_H screen with colour 000.
//
// Ports
//   clock       in   system clock
//   resetn      in   synchronous, active-low reset (aborts any operation)
//   req         in   per-requester box request, held high until ack
//   req_x       in   packed top-left x, 8 bits per requester
//   req_y       in   packed top-left y, 7 bits per requester
//   req_colour  in   packed colour, 3 bits per requester
//   clear_req   in   full-screen clear request, held high until clear_ack
//   ack         out  one-cycle pulse on ack[i] when box i is complete
//   clear_ack   out  one-cycle pulse when the clear is complete
//   busy        out  high whenever the scheduler is not idle
//   vga_x       out  pixel x to the adapter
//   vga_y       out  pixel y to the adapter
//   vga_colour  out  pixel colour to the adapter
//   vga_plot    out  write enable to the adapter
module vga_box_scheduler #(
  parameter int NUM_REQ = 2,
  parameter int BOX_W   = 4,
  parameter int BOX_H   = 4,
  parameter int SCR_W   = 160,
  parameter int SCR_H   = 120
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_x,
  input  logic [7*NUM_REQ-1:0] req_y,
  input  logic [3*NUM_REQ-1:0] req_colour,
  input  logic                 clear_req,
  output logic [NUM_REQ-1:0]   ack,
  output logic                 clear_ack,
  output logic                 busy,
  output logic [7:0]           vga_x,
  output logic [6:0]           vga_y,
  output logic [2:0]           vga_colour,
  output logic                 vga_plot
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int X_MAX = (BOX_W > SCR_W) ? BOX_W : SCR_W;
  localparam int Y_MAX = (BOX_H > SCR_H) ? BOX_H : SCR_H;
  localparam int CXW   = $clog2(X_MAX + 1);
  localparam int CYW   = $clog2(Y_MAX + 1);

  typedef enum logic [2:0] {
    IDLE,
    DRAW,
    DONE,
    CLEAR,
    CLR_DONE
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] rr_last;
  logic [IDX_W-1:0] grant;
  logic [IDX_W-1:0] pick;
  logic             found;
  int               idx;

  logic [7:0]       base_x;
  logic [6:0]       base_y;
  logic [7:0]       sel_x;
  logic [6:0]       sel_y;
  logic [2:0]       sel_colour;

  logic [CXW-1:0]   cx;
  logic [CXW-1:0]   cx_end;
  logic [CXW-1:0]   cx_next;
  logic [CYW-1:0]   cy;
  logic [CYW-1:0]   cy_end;
  logic [CYW-1:0]   cy_next;
  logic             x_wrap;
  logic             last_pixel;

  // Round-robin search starting just after the last requester served,
  // wrapping around; the first requester found with req high wins.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(rr_last) + k) % NUM_REQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = IDX_W'(idx);
      end
    end
  end

  assign sel_x      = req_x[8*pick +: 8];
  assign sel_y      = req_y[7*pick +: 7];
  assign sel_colour = req_colour[3*pick +: 3];

  // Shared raster counter: the scan limits depend on whether a box or the
  // whole screen is being walked. cx/cy always name the pixel currently
  // presented on the adapter port.
  always_comb begin
    cx_end     = (state == CLEAR) ? CXW'(SCR_W - 1) : CXW'(BOX_W - 1);
    cy_end     = (state == CLEAR) ? CYW'(SCR_H - 1) : CYW'(BOX_H - 1);
    x_wrap     = (cx == cx_end);
    last_pixel = x_wrap && (cy == cy_end);
    cx_next    = x_wrap ? '0 : cx + 1'b1;
    cy_next    = x_wrap ? cy + 1'b1 : cy;
  end

  // Scheduler FSM. Every output is a register loaded one cycle ahead, so the
  // first pixel appears in the cycle right after the arbitration edge and
  // there is no combinational path from req/clear_req to the adapter.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state      <= IDLE;
      rr_last    <= IDX_W'(NUM_REQ - 1);
      grant      <= '0;
      base_x     <= '0;
      base_y     <= '0;
      cx         <= '0;
      cy         <= '0;
      ack        <= '0;
      clear_ack  <= 1'b0;
      busy       <= 1'b0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      vga_plot   <= 1'b0;
    end else begin
      ack       <= '0;
      clear_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (clear_req) begin
            state      <= CLEAR;
            cx         <= '0;
            cy         <= '0;
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= 3'b000;
            vga_plot   <= 1'b1;
            busy       <= 1'b1;
          end else if (found) begin
            state      <= DRAW;
            grant      <= pick;
            base_x     <= sel_x;
            base_y     <= sel_y;
            cx         <= '0;
            cy         <= '0;
            vga_x      <= sel_x;
            vga_y      <= sel_y;
            vga_colour <= sel_colour;
            vga_plot   <= 1'b1;
            busy       <= 1'b1;
          end
        end
        DRAW: begin
          // Box coordinates wrap modulo the adapter widths rather than clip.
          if (last_pixel) begin
            state      <= DONE;
            vga_plot   <= 1'b0;
            ack[grant] <= 1'b1;
          end else begin
            cx    <= cx_next;
            cy    <= cy_next;
            vga_x <= base_x + 8'(cx_next);
            vga_y <= base_y + 7'(cy_next);
          end
        end
        DONE: begin
          rr_last <= grant;
          state   <= IDLE;
          busy    <= 1'b0;
        end
        CLEAR: begin
          if (last_pixel) begin
            state     <= CLR_DONE;
            vga_plot  <= 1'b0;
            clear_ack <= 1'b1;
          end else begin
            cx    <= cx_next;
            cy    <= cy_next;
            vga_x <= 8'(cx_next);
            vga_y <= 7'(cy_next);
          end
        end
        CLR_DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          vga_plot <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vga_box_scheduler.sv
// tb_vga_box_scheduler
// Scoreboard bench for vga_box_scheduler. Each round the stimulus side works
// out, from the round-robin/priority rules, the full list of adapter events
// (pixels, acks, clear_ack) it expects and queues them; an independent
// monitor compares every event the DUT presents against the queue head.
module tb_vga_box_scheduler;

  localparam int N  = 2;
  localparam int BW = 4;
  localparam int BH = 4;
  localparam int SW = 160;
  localparam int SH = 120;
  localparam int ROUND_BUDGET = 25000;

  logic           clock = 1'b0;
  logic           resetn = 1'b0;
  logic [N-1:0]   req = '0;
  logic [8*N-1:0] req_x = '0;
  logic [7*N-1:0] req_y = '0;
  logic [3*N-1:0] req_colour = '0;
  logic           clear_req = 1'b0;
  logic [N-1:0]   ack;
  logic           clear_ack;
  logic           busy;
  logic [7:0]     vga_x;
  logic [6:0]     vga_y;
  logic [2:0]     vga_colour;
  logic           vga_plot;

  vga_box_scheduler #(
    .NUM_REQ(N), .BOX_W(BW), .BOX_H(BH), .SCR_W(SW), .SCR_H(SH)
  ) dut (
    .clock(clock), .resetn(resetn), .req(req), .req_x(req_x), .req_y(req_y),
    .req_colour(req_colour), .clear_req(clear_req), .ack(ack),
    .clear_ack(clear_ack), .busy(busy), .vga_x(vga_x), .vga_y(vga_y),
    .vga_colour(vga_colour), .vga_plot(vga_plot)
  );

  always #5 clock = ~clock;

  // kind 0 = pixel, 1 = box ack, 2 = clear ack
  typedef struct {
    int kind;
    int x;
    int y;
    int c;
    int idx;
  } item_t;

  item_t expq[$];
  int    checks = 0;
  int    fails = 0;
  bit    mon_en = 1'b0;
  bit    expect_cont = 1'b0;
  bit    mon_any;
  int    mon_kind;
  item_t mon_item;

  int    m_last = N - 1;
  int    rem[N];
  int    used[N];
  int    bx[N][3];
  int    by[N][3];
  int    bc[N][3];

  // One comparison: counts it and reports it when it disagrees.
  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic pushItem(input int kind, input int x, input int y, input int c, input int idx);
    item_t it;
    it.kind = kind;
    it.x = x;
    it.y = y;
    it.c = c;
    it.idx = idx;
    expq.push_back(it);
  endtask

  // Reference: a box is its BW*BH pixels in raster order, coordinates taken
  // modulo 256/128, followed by one ack for its requester.
  task automatic pushBox(input int j, input int x, input int y, input int c);
    for (int r = 0; r < BH; r++)
      for (int q = 0; q < BW; q++)
        pushItem(0, (x + q) % 256, (y + r) % 128, c, j);
    pushItem(1, 0, 0, 0, j);
  endtask

  // Monitor: every adapter event the DUT shows must match the queue head,
  // and events within one job must come on consecutive cycles.
  always @(negedge clock) begin
    if (!mon_en) begin
      expect_cont = 1'b0;
    end else begin
      mon_any = vga_plot || (ack != '0) || clear_ack;
      if (expect_cont) checkOutput("no_stall", int'(mon_any), 1);
      expect_cont = 1'b0;
      mon_kind = -1;
      if (vga_plot) mon_kind = 0;
      else if (ack != '0) mon_kind = 1;
      else if (clear_ack) mon_kind = 2;
      if (mon_kind >= 0) begin
        checkOutput("busy_when_active", int'(busy), 1);
        if (expq.size() == 0) begin
          checkOutput("unexpected_event", mon_kind, -1);
        end else begin
          mon_item = expq[0];
          checkOutput("event_kind", mon_kind, mon_item.kind);
          if (mon_kind == mon_item.kind) begin
            mon_item = expq.pop_front();
            if (mon_kind == 0) begin
              checkOutput("pixel_x", int'(vga_x), mon_item.x);
              checkOutput("pixel_y", int'(vga_y), mon_item.y);
              checkOutput("pixel_colour", int'(vga_colour), mon_item.c);
              checkOutput("ack_during_plot", int'(ack), 0);
              expect_cont = 1'b1;
            end else if (mon_kind == 1) begin
              checkOutput("ack_vector", int'(ack), 1 << mon_item.idx);
            end else begin
              checkOutput("clear_ack_only", int'(ack), 0);
            end
          end
        end
      end
    end
  end

  // Synchronous reset, then every output must read zero.
  task automatic applyReset();
    @(negedge clock);
    mon_en = 1'b0;
    resetn = 1'b0;
    req = '0;
    clear_req = 1'b0;
    repeat (2) @(negedge clock);
    checkOutput("reset_plot", int'(vga_plot), 0);
    checkOutput("reset_ack", int'(ack), 0);
    checkOutput("reset_clear_ack", int'(clear_ack), 0);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_xy", int'({vga_x, vga_y, vga_colour}), 0);
    expq.delete();
    m_last = N - 1;
    resetn = 1'b1;
    mon_en = 1'b1;
  endtask

  // Builds the expected event list for the requests in rem/bx/by/bc (plus an
  // optional clear), then plays the requesters: each holds req until its
  // ack, loading its next box or dropping req when it has none left.
  // drop_after > 0 makes requester 0 drop req after that many plot cycles.
  task automatic applyStimulus(input bit clr, input int drop_after);
    int  left[N];
    int  nxt[N];
    int  pix;
    bit  done;
    bit  any_left;
    int  j;
    left = rem;
    for (int i = 0; i < N; i++) nxt[i] = 0;
    if (clr) begin
      for (int y = 0; y < SH; y++)
        for (int x = 0; x < SW; x++)
          pushItem(0, x, y, 0, 0);
      pushItem(2, 0, 0, 0, 0);
    end
    any_left = 1'b1;
    while (any_left) begin
      any_left = 1'b0;
      j = -1;
      for (int k = 1; k <= N; k++)
        if (j < 0 && left[(m_last + k) % N] > 0) j = (m_last + k) % N;
      if (j >= 0) begin
        pushBox(j, bx[j][nxt[j]], by[j][nxt[j]], bc[j][nxt[j]]);
        nxt[j]++;
        left[j]--;
        m_last = j;
        any_left = 1'b1;
      end
    end

    for (int i = 0; i < N; i++) begin
      used[i] = 0;
      req_x[8*i +: 8] = 8'(bx[i][0]);
      req_y[7*i +: 7] = 7'(by[i][0]);
      req_colour[3*i +: 3] = 3'(bc[i][0]);
      req[i] = (rem[i] > 0);
    end
    clear_req = clr;
    pix = 0;
    done = 1'b0;
    for (int cyc = 0; cyc < ROUND_BUDGET && !done; cyc++) begin
      @(negedge clock);
      if (drop_after > 0 && vga_plot) begin
        pix++;
        if (pix == drop_after) req[0] = 1'b0;
      end
      for (int i = 0; i < N; i++) begin
        if (ack[i]) begin
          used[i]++;
          rem[i]--;
          if (rem[i] <= 0) begin
            req[i] = 1'b0;
          end else begin
            req_x[8*i +: 8] = 8'(bx[i][used[i]]);
            req_y[7*i +: 7] = 7'(by[i][used[i]]);
            req_colour[3*i +: 3] = 3'(bc[i][used[i]]);
          end
        end
      end
      if (clear_ack) clear_req = 1'b0;
      if (req == '0 && !clear_req && !busy && expq.size() == 0) done = 1'b1;
    end
    checkOutput("round_completes", int'(done), 1);
    checkOutput("queue_drained", expq.size(), 0);
  endtask

  task automatic setBox(input int i, input int n, input int x, input int y, input int c);
    bx[i][n] = x;
    by[i][n] = y;
    bc[i][n] = c;
  endtask

  int pix6;

  initial begin
    for (int i = 0; i < N; i++) begin
      rem[i] = 0;
      for (int n = 0; n < 3; n++) setBox(i, n, 0, 0, 0);
    end

    applyReset();

    // Single box from requester 0
    $display("[TB] single box");
    rem[0] = 1; rem[1] = 0;
    setBox(0, 0, 10, 20, 5);
    applyStimulus(1'b0, 0);
    checkOutput("idle_after_box", int'(busy), 0);

    // Both requesters held high: alternation starting with requester 0
    $display("[TB] alternation");
    applyReset();
    rem[0] = 2; rem[1] = 2;
    setBox(0, 0, 1, 2, 1); setBox(0, 1, 3, 4, 2);
    setBox(1, 0, 50, 60, 3); setBox(1, 1, 70, 80, 4);
    applyStimulus(1'b0, 0);

    // Coordinate wrap at the top of both ranges
    $display("[TB] wrap");
    rem[0] = 1; rem[1] = 0;
    setBox(0, 0, 254, 126, 6);
    applyStimulus(1'b0, 0);

    // Clear and box requested together: clear first, then the box
    $display("[TB] clear priority");
    rem[0] = 1; rem[1] = 0;
    setBox(0, 0, 30, 40, 7);
    applyStimulus(1'b1, 0);

    // Reset in the middle of a box aborts it silently; the held req redraws
    $display("[TB] reset during draw");
    @(negedge clock);
    mon_en = 1'b0;
    req_x[7:0] = 8'd100;
    req_y[6:0] = 7'd50;
    req_colour[2:0] = 3'd3;
    req[0] = 1'b1;
    pix6 = 0;
    for (int cyc = 0; cyc < 40 && pix6 < 6; cyc++) begin
      @(negedge clock);
      if (vga_plot) pix6++;
    end
    checkOutput("reached_sixth_pixel", pix6, 6);
    resetn = 1'b0;
    @(negedge clock);
    checkOutput("abort_plot", int'(vga_plot), 0);
    checkOutput("abort_ack", int'(ack), 0);
    checkOutput("abort_busy", int'(busy), 0);
    checkOutput("abort_xy", int'({vga_x, vga_y, vga_colour}), 0);
    expq.delete();
    m_last = N - 1;
    resetn = 1'b1;
    mon_en = 1'b1;
    rem[0] = 1; rem[1] = 0;
    setBox(0, 0, 100, 50, 3);
    applyStimulus(1'b0, 0);

    // Requester 0 drops req after the 3rd pixel: box still finishes and acks
    $display("[TB] req dropped mid-box");
    rem[0] = 1; rem[1] = 0;
    setBox(0, 0, 77, 11, 2);
    applyStimulus(1'b0, 3);

    // Randomised rounds with random box counts and coordinates
    $display("[TB] random rounds");
    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < N; i++) begin
        rem[i] = $urandom_range(0, 3);
        for (int n = 0; n < 3; n++)
          setBox(i, n, $urandom_range(0, 255), $urandom_range(0, 127), $urandom_range(0, 7));
      end
      if (rem[0] == 0 && rem[1] == 0) rem[$urandom_range(0, N - 1)] = 1;
      applyStimulus(1'b0, 0);
    end

    repeat (3) @(negedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
